// File: rtl/dds_tone_sequencer.sv
// Tone sequencer feeding the DDS phase increment: plays a small table of
// (increment, duration) entries back-to-back, once or looping.
module dds_tone_sequencer #(
   parameter int DEPTH = 8,
   parameter int INC_W = 32,
   parameter int DUR_W = 24,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cfg_we,
   input  logic [AW-1:0]    i_cfg_addr,
   input  logic [INC_W-1:0] i_cfg_inc,
   input  logic [DUR_W-1:0] i_cfg_dur,
   input  logic [AW:0]      i_cfg_len,
   input  logic             i_loop,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_pause,
   output logic [INC_W-1:0] o_m_out,
   output logic             o_tone_stb,
   output logic [AW-1:0]    o_idx,
   output logic             o_busy,
   output logic             o_done,
   output logic [1:0]       o_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PLAY   = 2'd1,
      S_PAUSED = 2'd2
   } state_t;

   state_t           r_state;
   logic [INC_W-1:0] r_inc [DEPTH];
   logic [DUR_W-1:0] r_dur [DEPTH];
   logic [DUR_W-1:0] r_timer;
   logic [AW:0]      r_len;
   logic [INC_W-1:0] r_m_out;
   logic [AW-1:0]    r_idx;
   logic             r_tone_stb;
   logic             r_done;

   state_t           w_state_nxt;
   logic [DUR_W-1:0] w_timer_nxt;
   logic [AW:0]      w_len_nxt;
   logic [INC_W-1:0] w_m_nxt;
   logic [AW-1:0]    w_idx_nxt;
   logic             w_stb_nxt;
   logic             w_done_nxt;

   logic             w_len_ok;
   logic             w_last;
   logic [AW-1:0]    w_load_idx;
   logic [DUR_W-1:0] w_load_time;
   logic [DUR_W-1:0] w_first_time;

   assign w_len_ok     = (i_cfg_len != '0) && (i_cfg_len <= (AW+1)'(DEPTH));
   assign w_last       = (({1'b0, r_idx} + (AW+1)'(1)) >= r_len);
   assign w_load_idx   = w_last ? '0 : (r_idx + AW'(1));
   // A zero duration still shows the entry for one cycle.
   assign w_load_time  = (r_dur[w_load_idx] == '0) ? DUR_W'(1) : r_dur[w_load_idx];
   assign w_first_time = (r_dur[0] == '0) ? DUR_W'(1) : r_dur[0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_inc[i] <= '0;
            r_dur[i] <= '0;
         end
      end else if (i_cfg_we) begin
         r_inc[i_cfg_addr] <= i_cfg_inc;
         r_dur[i_cfg_addr] <= i_cfg_dur;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_timer    <= '0;
         r_len      <= '0;
         r_m_out    <= '0;
         r_idx      <= '0;
         r_tone_stb <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_timer    <= w_timer_nxt;
         r_len      <= w_len_nxt;
         r_m_out    <= w_m_nxt;
         r_idx      <= w_idx_nxt;
         r_tone_stb <= w_stb_nxt;
         r_done     <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_len_nxt   = r_len;
      w_m_nxt     = r_m_out;
      w_idx_nxt   = r_idx;
      w_stb_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_start && !i_stop && w_len_ok) begin
               w_state_nxt = S_PLAY;
               w_len_nxt   = i_cfg_len;
               w_idx_nxt   = '0;
               w_m_nxt     = r_inc[0];
               w_timer_nxt = w_first_time;
               w_stb_nxt   = 1'b1;
            end
         end
         S_PLAY, S_PAUSED: begin
            if (i_stop) begin
               w_state_nxt = S_IDLE;
               w_m_nxt     = '0;
               w_idx_nxt   = '0;
               w_timer_nxt = '0;
            end else if (i_pause) begin
               w_state_nxt = S_PAUSED;
            end else begin
               // Leaving pause counts as a normal play cycle, so a pause of N
               // cycles stretches the current entry by exactly N.
               w_state_nxt = S_PLAY;
               if (r_timer <= DUR_W'(1)) begin
                  if (!w_last || i_loop) begin
                     w_idx_nxt   = w_load_idx;
                     w_m_nxt     = r_inc[w_load_idx];
                     w_timer_nxt = w_load_time;
                     w_stb_nxt   = 1'b1;
                     if (w_last && w_len_ok) w_len_nxt = i_cfg_len;
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_m_nxt     = '0;
                     w_idx_nxt   = '0;
                     w_timer_nxt = '0;
                     w_done_nxt  = 1'b1;
                  end
               end else begin
                  w_timer_nxt = r_timer - DUR_W'(1);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign o_m_out    = r_m_out;
   assign o_tone_stb = r_tone_stb;
   assign o_idx      = r_idx;
   assign o_busy     = (r_state != S_IDLE);
   assign o_done     = r_done;
   assign o_state    = r_state;

endmodule

// File: tb/tb_dds_tone_sequencer.sv
// Bench for dds_tone_sequencer: directed scenarios plus randomized tables and
// pauses, compared cycle by cycle against an expected-output list model.
module tb_dds_tone_sequencer;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_cfg_we = 1'b0;
   logic [2:0]  i_cfg_addr = '0;
   logic [31:0] i_cfg_inc = '0;
   logic [23:0] i_cfg_dur = '0;
   logic [3:0]  i_cfg_len = '0;
   logic        i_loop = 1'b0;
   logic        i_start = 1'b0;
   logic        i_stop = 1'b0;
   logic        i_pause = 1'b0;
   logic [31:0] o_m_out;
   logic        o_tone_stb;
   logic [2:0]  o_idx;
   logic        o_busy;
   logic        o_done;
   logic [1:0]  o_state;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] m_inc [8];
   logic [23:0] m_dur [8];

   dds_tone_sequencer #(.DEPTH(8), .INC_W(32), .DUR_W(24)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr),
      .i_cfg_inc(i_cfg_inc), .i_cfg_dur(i_cfg_dur), .i_cfg_len(i_cfg_len),
      .i_loop(i_loop), .i_start(i_start), .i_stop(i_stop), .i_pause(i_pause),
      .o_m_out(o_m_out), .o_tone_stb(o_tone_stb), .o_idx(o_idx), .o_busy(o_busy),
      .o_done(o_done), .o_state(o_state)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) begin
         m_inc[i] = '0;
         m_dur[i] = '0;
      end
   endtask

   task automatic wr(input int a, input logic [31:0] inc, input logic [23:0] dur);
      i_cfg_we = 1'b1;
      i_cfg_addr = a[2:0];
      i_cfg_inc = inc;
      i_cfg_dur = dur;
      @(negedge clk);
      i_cfg_we = 1'b0;
      m_inc[a] = inc;
      m_dur[a] = dur;
   endtask

   task automatic check_idle(input string tag, input logic exp_done);
      check({tag, "_m"}, 64'(o_m_out), 64'd0);
      check({tag, "_idx"}, 64'(o_idx), 64'd0);
      check({tag, "_busy"}, 64'(o_busy), 64'd0);
      check({tag, "_done"}, 64'(o_done), 64'(exp_done));
   endtask

   // Expected output is a list of cycles: each entry shown max(dur,1) times;
   // a pause of p cycles starting at cycle k repeats cycle k's output p times.
   task automatic play(input int len, input int k, input int p);
      logic [31:0] exp_q[$];
      logic [2:0]  idx_q[$];
      logic        stb_q[$];
      int d, n, kk;
      for (int i = 0; i < len; i++) begin
         d = (m_dur[i] == 0) ? 1 : int'(m_dur[i]);
         for (int j = 0; j < d; j++) begin
            exp_q.push_back(m_inc[i]);
            idx_q.push_back(3'(i));
            stb_q.push_back(j == 0);
         end
      end
      kk = (p > 0) ? (k % exp_q.size()) : 0;
      for (int j = 0; j < p; j++) begin
         exp_q.insert(kk + 1, exp_q[kk]);
         idx_q.insert(kk + 1, idx_q[kk]);
         stb_q.insert(kk + 1, 1'b0);
      end
      n = exp_q.size();
      i_cfg_len = 4'(len);
      i_start = 1'b1;
      for (int c = 0; c <= n + 1; c++) begin
         @(negedge clk);
         i_start = 1'b0;
         if (c < n) begin
            check("play_m", 64'(o_m_out), 64'(exp_q[c]));
            check("play_idx", 64'(o_idx), 64'(idx_q[c]));
            check("play_stb", 64'(o_tone_stb), 64'(stb_q[c]));
            check("play_busy", 64'(o_busy), 64'd1);
            check("play_done", 64'(o_done), 64'd0);
         end else if (c == n) begin
            check_idle("play_end", 1'b1);
         end else begin
            check("play_done_once", 64'(o_done), 64'd0);
         end
         i_pause = (p > 0) && (c >= kk) && (c < kk + p);
      end
      i_pause = 1'b0;
   endtask

   initial begin
      clear_model();
      repeat (3) @(negedge clk);
      i_rst = 1'b0;
      check_idle("reset", 1'b0);
      check("reset_stb", 64'(o_tone_stb), 64'd0);
      check("reset_state", 64'(o_state), 64'd0);

      // T1: basic one-shot
      wr(0, 32'd4, 24'd3);
      wr(1, 32'd8, 24'd2);
      play(2, 0, 0);

      // T2: looping, then LOOP dropped during entry1 ends at the next wrap
      i_loop = 1'b1;
      i_cfg_len = 4'd2;
      i_start = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         i_start = 1'b0;
         check("loop_m", 64'(o_m_out), ((c % 5) < 3) ? 64'd4 : 64'd8);
         check("loop_done", 64'(o_done), 64'd0);
         if (c == 13) i_loop = 1'b0;
      end
      @(negedge clk);
      check_idle("loop_end", 1'b1);

      // T3: zero duration and illegal lengths
      wr(2, 32'd77, 24'd0);
      wr(0, 32'd5, 24'd0);
      play(1, 0, 0);
      i_cfg_len = 4'd0;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check_idle("len0", 1'b0);
      i_cfg_len = 4'd9;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check_idle("len9", 1'b0);

      // T4: pause mid-entry0, and pause on an expiry cycle
      wr(0, 32'd4, 24'd3);
      play(2, 1, 5);
      play(2, 2, 3);

      // T5: stop during entry1, stop+start in idle, reset mid-play
      i_cfg_len = 4'd2;
      i_start = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         i_start = 1'b0;
         check("stop_pre_m", 64'(o_m_out), (c < 3) ? 64'd4 : 64'd8);
         if (c == 3) i_stop = 1'b1;
      end
      @(negedge clk);
      i_stop = 1'b0;
      check_idle("stop", 1'b0);
      @(negedge clk);
      check("stop_no_done", 64'(o_done), 64'd0);
      i_start = 1'b1;
      i_stop = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_stop = 1'b0;
      check_idle("stop_start", 1'b0);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check("rst_pre_busy", 64'(o_busy), 64'd1);
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      clear_model();
      check_idle("rst_mid", 1'b0);
      check("rst_mid_stb", 64'(o_tone_stb), 64'd0);
      play(2, 0, 0);

      // T6: table rewrites during playback
      wr(0, 32'd4, 24'd3);
      wr(1, 32'd8, 24'd2);
      i_cfg_len = 4'd2;
      i_start = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         i_start = 1'b0;
         i_cfg_we = 1'b0;
         if (c < 5) check("rewr_m", 64'(o_m_out), (c < 3) ? 64'd4 : 64'd20);
         else check_idle("rewr_end", 1'b1);
         if (c == 0) begin
            i_cfg_we = 1'b1; i_cfg_addr = 3'd1; i_cfg_inc = 32'd20; i_cfg_dur = 24'd2;
         end else if (c == 1) begin
            i_cfg_we = 1'b1; i_cfg_addr = 3'd0; i_cfg_inc = 32'd99; i_cfg_dur = 24'd3;
         end
      end
      m_inc[1] = 32'd20;
      m_inc[0] = 32'd99;
      play(2, 0, 0);

      // Randomized tables, lengths and pauses
      for (int r = 0; r < 12; r++) begin
         for (int a = 0; a < 8; a++) wr(a, $urandom, 24'($urandom_range(0, 4)));
         if ($urandom_range(0, 1) == 1)
            play(int'($urandom_range(1, 8)), int'($urandom_range(0, 1000)), int'($urandom_range(1, 4)));
         else
            play(int'($urandom_range(1, 8)), 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
